i2s_multibank_buffer: RTL and testbench
=======================================

// Module: i2s_multibank_buffer
// PURPOSE
//  Multi-channel, N-bank frame buffer between the I2S receiver and frame consumers (lock-in, FFT).
//  Writer fills one bank with BUFFER_DEPTH frames; each frame carries all channels.
//  Full banks are queued oldest-first. The reader acquires and releases banks with an explicit handshake.
//  Overruns are detected and counted, never silent.
// PARAMETERS
//  DATA_WIDTH    24   bits per sample
//  BUFFER_DEPTH  512  frames per bank; power of 2, >=2
//  NUM_CHANNELS  2    channels per frame, 1..8
//  NUM_BANKS     3    banks, 2..4
//  OVERRUN_MODE  0    0 = drop incoming frames when no bank is free
//                     1 = reclaim the oldest READY bank (falls back to drop if none)
// PORTS
//  clk             in   1                     system clock
//  reset           in   1                     asynchronous, active-high
//  i_audio_valid   in   1                     one frame present on i_audio_data
//  i_audio_data    in   NUM_CHANNELS*DATA_WIDTH  ch0 in LSBs
//  i_frame_take    in   1                     acquire head of ready queue (pulse)
//  i_frame_release in   1                     return the held bank (pulse)
//  i_read_addr     in   clog2(BUFFER_DEPTH)   frame index within held bank
//  i_read_ch       in   max(1,clog2(NUM_CHANNELS))  channel select
//  o_data_out      out  DATA_WIDTH            registered read data
//  o_frame_avail   out  1                     ready queue non-empty
//  o_read_active   out  1                     reader holds a bank
//  o_frame_done    out  1                     1-cycle pulse: a bank was queued
//  o_overrun       out  1                     1-cycle pulse: frame dropped or bank reclaimed
//  o_drop_count    out  16                    saturating count of dropped frames + reclaimed banks
//  o_ready_count   out  clog2(NUM_BANKS+1)    banks in ready queue
// BEHAVIOUR
//  Reset (async): all outputs 0. All banks FREE except bank 0. Writer FILL on bank 0 at addr 0. Queue empty. Memory not reset.
//  Bank states: FREE -> FILLING -> READY (queued) -> HELD -> FREE. Writer owns <=1 bank; reader owns <=1 bank.
//  Memory index = (bank*NUM_CHANNELS + ch)*BUFFER_DEPTH + addr. All channels written in the same cycle.
//  Writer states:
//   FILL: on valid, write frame at write_addr, write_addr++.
//    At addr BUFFER_DEPTH-1 with valid: push bank to queue tail and pulse o_frame_done.
//    Same cycle: take lowest-index FREE bank, addr <= 0, stay FILL.
//    If no bank is FREE: mode 0 -> STALL. Mode 1 with queue non-empty -> pop head, reuse it, pulse o_overrun, count+1.
//   STALL: each valid frame is dropped; o_overrun pulses and count+1 per frame.
//    First cycle with a FREE bank (as registered state): take it, addr <= 0, -> FILL. A valid frame in that cycle is still dropped.
//  Reader:
//   take while avail=1 and not active: pop head into held bank, read_active <= 1.
//   take while active: old held bank -> FREE, head becomes held.
//   take while avail=0: ignored.
//   release while active: bank -> FREE, read_active <= 0. Release while idle: ignored.
//  Simultaneous events:
//   A bank completing and a take in the same cycle with the queue empty: take is ignored; the bank is visible next cycle.
//   Push and pop in the same cycle: both apply, o_ready_count unchanged.
//   A bank freed by take/release is not allocatable by the writer until the next cycle.
//   Mode 1 never reclaims the held bank.
//  Read latency 1: o_data_out <= mem[held, i_read_ch, i_read_addr]; 0 when read_active=0.
//  i_read_ch >= NUM_CHANNELS gives 0.
//  o_drop_count saturates at 16'hFFFF; cleared only by reset.
//  Reset mid-frame: partial bank discarded, queue emptied, held bank lost; no o_frame_done.
// TESTING
//  1. Defaults, 512 valid frames ramp ch0=n, ch1=~n -> o_frame_done on frame 511, avail=1; take, read addr 5 ch1 -> ~5 one cycle later.
//  2. Bank hand-off: fill 3 banks without take -> ready_count=2 after bank 1, writer STALL after bank 2; 4 more frames -> drop_count=4, 4 overrun pulses.
//  3. Mode 1, same stimulus -> bank 0 reclaimed on 3rd completion, ready order becomes 1,2; drop_count=1.
//  4. Take/release: take, release, take -> first held=0, then bank 1; bank 0 re-filled by writer after the release cycle.
//  5. Same-cycle frame completion and take with queue empty -> take ignored, avail=1 next cycle, read_active stays 0.
//  6. Assert reset at frame 300 of bank 1 with bank 0 held -> all outputs 0 immediately; next 512 frames land in bank 0.

Source files
------------

// File: rtl/i2s_multibank_buffer.sv
// i2s_multibank_buffer
//   N-bank, multi-channel frame buffer between the I2S receiver and frame
//   consumers. The writer fills one bank with BUFFER_DEPTH frames, where each
//   frame holds every channel. Full banks are queued oldest-first. The reader
//   acquires banks with a take pulse and returns them with a release pulse.
//   Dropped frames and reclaimed banks are reported on o_overrun and counted
//   in o_drop_count.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   i_audio_valid     one frame is present on i_audio_data
//   i_audio_data      NUM_CHANNELS samples, ch0 in the LSBs
//   i_frame_take      acquire the head of the ready queue (pulse)
//   i_frame_release   return the held bank (pulse)
//   i_read_addr       frame index within the held bank
//   i_read_ch         channel select
//   o_data_out        registered read data, 0 while no bank is held
//   o_frame_avail     ready queue non-empty
//   o_read_active     reader holds a bank
//   o_frame_done      1-cycle pulse when a bank is queued
//   o_overrun         1-cycle pulse when a frame is dropped or a bank reclaimed
//   o_drop_count      saturating count of dropped frames plus reclaimed banks
//   o_ready_count     number of banks in the ready queue
module i2s_multibank_buffer #(
  parameter int DATA_WIDTH   = 24,
  parameter int BUFFER_DEPTH = 512,
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_BANKS    = 3,
  parameter int OVERRUN_MODE = 0,
  localparam int AW  = $clog2(BUFFER_DEPTH),
  localparam int CW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int RCW = $clog2(NUM_BANKS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_audio_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_audio_data,
  input  logic                             i_frame_take,
  input  logic                             i_frame_release,
  input  logic [AW-1:0]                    i_read_addr,
  input  logic [CW-1:0]                    i_read_ch,
  output logic [DATA_WIDTH-1:0]            o_data_out,
  output logic                             o_frame_avail,
  output logic                             o_read_active,
  output logic                             o_frame_done,
  output logic                             o_overrun,
  output logic [15:0]                      o_drop_count,
  output logic [RCW-1:0]                   o_ready_count
);

  localparam int BW        = $clog2(NUM_BANKS);
  localparam int MEM_WORDS = NUM_BANKS * NUM_CHANNELS * BUFFER_DEPTH;
  localparam int MW        = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUFFER_DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_READY,
    BANK_HELD
  } bank_state_t;

  typedef enum logic {
    WR_FILL,
    WR_STALL
  } wr_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  wr_state_t       wr_state_q, wr_state_d;
  logic [BW-1:0]   wr_bank_q, wr_bank_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  bank_state_t     bank_st_q [NUM_BANKS];
  bank_state_t     bank_st_d [NUM_BANKS];
  logic [BW-1:0]   queue_q [NUM_BANKS];
  logic [BW-1:0]   queue_d [NUM_BANKS];
  logic [RCW-1:0]  q_cnt_q, q_cnt_d;
  logic [BW-1:0]   held_q, held_d;
  logic            active_q, active_d;
  logic [15:0]     drop_q, drop_d;
  logic            done_d, ovr_d;

  logic            take_ok, complete, push, bump, free_found;
  logic [BW-1:0]   free_bank;
  int unsigned     n_pop, cnt;

  logic                  rd_ch_ok;
  logic [MW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  function automatic logic [MW-1:0] mem_index(input logic [BW-1:0] bank,
                                              input int unsigned ch,
                                              input logic [AW-1:0] addr);
    int unsigned idx;
    idx = (32'(bank) * NUM_CHANNELS + ch) * BUFFER_DEPTH + 32'(addr);
    return MW'(idx);
  endfunction

  // Frame write: every channel of the frame lands in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_state_q == WR_FILL && i_audio_valid) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        mem[mem_index(wr_bank_q, c, wr_addr_q)] <= i_audio_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_ch_ok = 32'(i_read_ch) < NUM_CHANNELS;
    rd_idx   = mem_index(held_q, 32'(i_read_ch), i_read_addr);
    rd_data  = (active_q && rd_ch_ok) ? mem[rd_idx] : '0;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    bank_st_d  = bank_st_q;
    queue_d    = queue_q;
    q_cnt_d    = q_cnt_q;
    held_d     = held_q;
    active_d   = active_q;
    drop_d     = drop_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    push       = 1'b0;
    bump       = 1'b0;
    n_pop      = 0;
    cnt        = 0;

    // Allocation looks only at registered state, so a bank freed by the
    // reader this cycle becomes allocatable one cycle later.
    free_found = 1'b0;
    free_bank  = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (!free_found && bank_st_q[b] == BANK_FREE) begin
        free_found = 1'b1;
        free_bank  = BW'(b);
      end
    end

    take_ok  = i_frame_take && (q_cnt_q != '0);
    complete = (wr_state_q == WR_FILL) && i_audio_valid && (wr_addr_q == LAST_ADDR);

    if (take_ok) begin
      if (active_q) bank_st_d[held_q] = BANK_FREE;
      bank_st_d[queue_q[0]] = BANK_HELD;
      held_d   = queue_q[0];
      active_d = 1'b1;
      n_pop    = 1;
    end else if (i_frame_release && active_q) begin
      bank_st_d[held_q] = BANK_FREE;
      active_d = 1'b0;
    end

    case (wr_state_q)
      WR_FILL: begin
        if (i_audio_valid) begin
          if (!complete) begin
            wr_addr_d = wr_addr_q + 1'b1;
          end else begin
            bank_st_d[wr_bank_q] = BANK_READY;
            done_d    = 1'b1;
            push      = 1'b1;
            wr_addr_d = '0;
            if (free_found) begin
              wr_bank_d = free_bank;
              bank_st_d[free_bank] = BANK_FILLING;
            end else if (OVERRUN_MODE == 1 && 32'(q_cnt_q) > n_pop) begin
              // Reclaim the oldest queued bank not already taken by the
              // reader in this same cycle; the held bank is never in the queue.
              wr_bank_d = queue_q[n_pop];
              bank_st_d[queue_q[n_pop]] = BANK_FILLING;
              n_pop = n_pop + 1;
              ovr_d = 1'b1;
              bump  = 1'b1;
            end else begin
              wr_state_d = WR_STALL;
            end
          end
        end
      end
      WR_STALL: begin
        if (i_audio_valid) begin
          ovr_d = 1'b1;
          bump  = 1'b1;
        end
        if (free_found) begin
          wr_bank_d  = free_bank;
          wr_addr_d  = '0;
          bank_st_d[free_bank] = BANK_FILLING;
          wr_state_d = WR_FILL;
        end
      end
      default: wr_state_d = WR_FILL;
    endcase

    // Pops (reader first, then reclaim) come off the head; the completed
    // bank is appended after them, so push+pop leaves the count unchanged.
    if (n_pop != 0 || push) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        queue_d[i] = (i + n_pop < NUM_BANKS) ? queue_q[i + n_pop] : '0;
      end
      cnt = 32'(q_cnt_q) - n_pop;
      if (push) begin
        queue_d[cnt] = wr_bank_q;
        cnt = cnt + 1;
      end
      q_cnt_d = RCW'(cnt);
    end

    if (bump && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_FILL;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        bank_st_q[b] <= (b == 0) ? BANK_FILLING : BANK_FREE;
        queue_q[b]   <= '0;
      end
      q_cnt_q      <= '0;
      held_q       <= '0;
      active_q     <= 1'b0;
      drop_q       <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      o_data_out   <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      bank_st_q    <= bank_st_d;
      queue_q      <= queue_d;
      q_cnt_q      <= q_cnt_d;
      held_q       <= held_d;
      active_q     <= active_d;
      drop_q       <= drop_d;
      o_frame_done <= done_d;
      o_overrun    <= ovr_d;
      o_data_out   <= rd_data;
    end
  end

  assign o_frame_avail = (q_cnt_q != '0);
  assign o_read_active = active_q;
  assign o_drop_count  = drop_q;
  assign o_ready_count = q_cnt_q;

endmodule

// File: tb/tb_i2s_multibank_buffer.sv
// Directed bench for i2s_multibank_buffer. Two instances share all inputs:
// u_m0 uses drop-on-overrun, u_m1 reclaims the oldest ready bank.
module tb_i2s_multibank_buffer;

  localparam int DW = 24;
  localparam int AW = 9;
  localparam int CW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_audio_valid;
  logic [2*DW-1:0] i_audio_data;
  logic          i_frame_take;
  logic          i_frame_release;
  logic [AW-1:0] i_read_addr;
  logic [CW-1:0] i_read_ch;

  logic [DW-1:0] m0_data, m1_data;
  logic          m0_avail, m1_avail, m0_active, m1_active;
  logic          m0_done, m1_done, m0_ovr, m1_ovr;
  logic [15:0]   m0_drop, m1_drop;
  logic [1:0]    m0_ready, m1_ready;

  int tests_run = 0;
  int tests_failed = 0;
  int done0, done1, ovr0, ovr1, done_idx0;

  always #5 clk = ~clk;

  i2s_multibank_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(512), .NUM_CHANNELS(2),
                         .NUM_BANKS(3), .OVERRUN_MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .i_audio_valid(i_audio_valid), .i_audio_data(i_audio_data),
    .i_frame_take(i_frame_take), .i_frame_release(i_frame_release),
    .i_read_addr(i_read_addr), .i_read_ch(i_read_ch),
    .o_data_out(m0_data), .o_frame_avail(m0_avail), .o_read_active(m0_active),
    .o_frame_done(m0_done), .o_overrun(m0_ovr), .o_drop_count(m0_drop),
    .o_ready_count(m0_ready));

  i2s_multibank_buffer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(512), .NUM_CHANNELS(2),
                         .NUM_BANKS(3), .OVERRUN_MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .i_audio_valid(i_audio_valid), .i_audio_data(i_audio_data),
    .i_frame_take(i_frame_take), .i_frame_release(i_frame_release),
    .i_read_addr(i_read_addr), .i_read_ch(i_read_ch),
    .o_data_out(m1_data), .o_frame_avail(m1_avail), .o_read_active(m1_active),
    .o_frame_done(m1_done), .o_overrun(m1_ovr), .o_drop_count(m1_drop),
    .o_ready_count(m1_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_audio_valid = 1'b0;
    i_frame_take = 1'b0;
    i_frame_release = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Frame n of a run carries ch0 = base+n, ch1 = ~(base+n).
  task automatic send_frames(input int n, input int base);
    logic [DW-1:0] v;
    done0 = 0; done1 = 0; ovr0 = 0; ovr1 = 0; done_idx0 = -1;
    for (int i = 0; i < n; i++) begin
      v = DW'(base + i);
      i_audio_valid = 1'b1;
      i_audio_data = {~v, v};
      step();
      if (m0_done) begin done0++; done_idx0 = i; end
      if (m1_done) done1++;
      if (m0_ovr) ovr0++;
      if (m1_ovr) ovr1++;
    end
    i_audio_valid = 1'b0;
  endtask

  task automatic pulse_take();
    i_frame_take = 1'b1;
    step();
    i_frame_take = 1'b0;
  endtask

  task automatic test_reset();
    i_audio_valid = 1'b0; i_audio_data = '0; i_frame_take = 1'b0;
    i_frame_release = 1'b0; i_read_addr = '0; i_read_ch = '0;
    reset = 1'b0;
    #3 reset = 1'b1;
    #1;
    tests_run++; if ({m0_data, m0_avail, m0_active, m0_done, m0_ovr, m0_drop, m0_ready} !== '0) begin tests_failed++; $display("FAIL reset_m0_outputs: got %0h expected 0", {m0_data, m0_avail, m0_active, m0_done, m0_ovr, m0_drop, m0_ready}); end
    tests_run++; if ({m1_data, m1_avail, m1_active, m1_done, m1_ovr, m1_drop, m1_ready} !== '0) begin tests_failed++; $display("FAIL reset_m1_outputs: got %0h expected 0", {m1_data, m1_avail, m1_active, m1_done, m1_ovr, m1_drop, m1_ready}); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill_read();
    send_frames(512, 0);
    tests_run++; if (done0 !== 1) begin tests_failed++; $display("FAIL fill_done_count: got %0d expected 1", done0); end
    tests_run++; if (done_idx0 !== 511) begin tests_failed++; $display("FAIL fill_done_frame: got %0d expected 511", done_idx0); end
    tests_run++; if (m0_avail !== 1'b1) begin tests_failed++; $display("FAIL fill_avail: got %0b expected 1", m0_avail); end
    i_read_addr = 9'd5; i_read_ch = 1'b1;
    pulse_take();
    tests_run++; if (m0_active !== 1'b1) begin tests_failed++; $display("FAIL take_active: got %0b expected 1", m0_active); end
    tests_run++; if (m0_ready !== 2'd0) begin tests_failed++; $display("FAIL take_ready: got %0d expected 0", m0_ready); end
    step();
    tests_run++; if (m0_data !== 24'hFFFFFA) begin tests_failed++; $display("FAIL read_a5_ch1: got %0h expected fffffa", m0_data); end
    i_read_addr = 9'd511; i_read_ch = 1'b0;
    step();
    tests_run++; if (m0_data !== 24'd511) begin tests_failed++; $display("FAIL read_a511_ch0: got %0h expected 1ff", m0_data); end
  endtask

  task automatic test_bank_handoff();
    send_frames(512, 0);
    tests_run++; if (m0_ready !== 2'd1) begin tests_failed++; $display("FAIL handoff_ready_b0: got %0d expected 1", m0_ready); end
    send_frames(512, 512);
    tests_run++; if (m0_ready !== 2'd2) begin tests_failed++; $display("FAIL handoff_ready_b1: got %0d expected 2", m0_ready); end
    send_frames(512, 1024);
    tests_run++; if (m0_ready !== 2'd3) begin tests_failed++; $display("FAIL handoff_ready_b2: got %0d expected 3", m0_ready); end
    tests_run++; if (m0_drop !== 16'd0) begin tests_failed++; $display("FAIL handoff_drop_b2: got %0d expected 0", m0_drop); end
    tests_run++; if (m1_ready !== 2'd2) begin tests_failed++; $display("FAIL reclaim_ready: got %0d expected 2", m1_ready); end
    tests_run++; if (ovr1 !== 1 || m1_drop !== 16'd1) begin tests_failed++; $display("FAIL reclaim_overrun: got ovr=%0d drop=%0d expected ovr=1 drop=1", ovr1, m1_drop); end
    send_frames(4, 1536);
    tests_run++; if (ovr0 !== 4 || m0_drop !== 16'd4) begin tests_failed++; $display("FAIL stall_drops: got ovr=%0d drop=%0d expected ovr=4 drop=4", ovr0, m0_drop); end
    tests_run++; if (done0 !== 0) begin tests_failed++; $display("FAIL stall_no_done: got %0d expected 0", done0); end
    tests_run++; if (ovr1 !== 0 || m1_drop !== 16'd1) begin tests_failed++; $display("FAIL reclaim_no_more_drops: got ovr=%0d drop=%0d expected ovr=0 drop=1", ovr1, m1_drop); end
    i_read_addr = 9'd5; i_read_ch = 1'b0;
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd5) begin tests_failed++; $display("FAIL order_m0_first: got %0d expected 5", m0_data); end
    tests_run++; if (m1_data !== 24'd517) begin tests_failed++; $display("FAIL order_m1_first: got %0d expected 517", m1_data); end
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd517) begin tests_failed++; $display("FAIL order_m0_second: got %0d expected 517", m0_data); end
    tests_run++; if (m1_data !== 24'd1029) begin tests_failed++; $display("FAIL order_m1_second: got %0d expected 1029", m1_data); end
  endtask

  task automatic test_take_release();
    send_frames(512, 0);
    send_frames(512, 512);
    i_read_addr = 9'd5; i_read_ch = 1'b0;
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd5) begin tests_failed++; $display("FAIL tr_first_held: got %0d expected 5", m0_data); end
    i_frame_release = 1'b1;
    step();
    i_frame_release = 1'b0;
    tests_run++; if (m0_active !== 1'b0) begin tests_failed++; $display("FAIL tr_release_active: got %0b expected 0", m0_active); end
    step();
    tests_run++; if (m0_data !== 24'd0) begin tests_failed++; $display("FAIL tr_idle_data: got %0d expected 0", m0_data); end
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd517) begin tests_failed++; $display("FAIL tr_second_held: got %0d expected 517", m0_data); end
    send_frames(512, 1024);
    send_frames(512, 2000);
    tests_run++; if (done0 !== 1 || m0_ready !== 2'd2) begin tests_failed++; $display("FAIL tr_refill_b0: got done=%0d ready=%0d expected done=1 ready=2", done0, m0_ready); end
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd1029) begin tests_failed++; $display("FAIL tr_held_b2: got %0d expected 1029", m0_data); end
    pulse_take();
    step();
    tests_run++; if (m0_data !== 24'd2005) begin tests_failed++; $display("FAIL tr_held_b0_refill: got %0d expected 2005", m0_data); end
  endtask

  task automatic test_take_on_complete();
    logic [DW-1:0] v;
    send_frames(511, 0);
    v = DW'(511);
    i_audio_valid = 1'b1; i_audio_data = {~v, v};
    i_frame_take = 1'b1;
    step();
    i_audio_valid = 1'b0; i_frame_take = 1'b0;
    tests_run++; if (m0_done !== 1'b1 || m0_avail !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_done_avail: got done=%0b avail=%0b expected 1 1", m0_done, m0_avail); end
    tests_run++; if (m0_active !== 1'b0 || m0_ready !== 2'd1) begin tests_failed++; $display("FAIL same_cycle_take_ignored: got active=%0b ready=%0d expected 0 1", m0_active, m0_ready); end
    step();
    tests_run++; if (m0_active !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_active_later: got %0b expected 0", m0_active); end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] v;
    send_frames(512, 0);
    i_read_addr = 9'd5; i_read_ch = 1'b0;
    pulse_take();
    send_frames(300, 512);
    tests_run++; if (m0_active !== 1'b1 || m0_data !== 24'd5) begin tests_failed++; $display("FAIL mid_pre_reset: got active=%0b data=%0d expected 1 5", m0_active, m0_data); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if ({m0_data, m0_avail, m0_active, m0_done, m0_ovr, m0_drop, m0_ready} !== '0) begin tests_failed++; $display("FAIL mid_reset_outputs: got %0h expected 0", {m0_data, m0_avail, m0_active, m0_done, m0_ovr, m0_drop, m0_ready}); end
    step();
    reset = 1'b0;
    step();
    send_frames(512, 7000);
    tests_run++; if (done0 !== 1 || done_idx0 !== 511) begin tests_failed++; $display("FAIL mid_refill_done: got count=%0d idx=%0d expected 1 511", done0, done_idx0); end
    i_read_addr = 9'd5; i_read_ch = 1'b1;
    pulse_take();
    step();
    v = DW'(7005);
    tests_run++; if (m0_data !== ~v) begin tests_failed++; $display("FAIL mid_refill_data: got %0h expected %0h", m0_data, ~v); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    do_reset();
    test_bank_handoff();
    do_reset();
    test_take_release();
    do_reset();
    test_take_on_complete();
    do_reset();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
